// File: rtl/alpha_feed_pkg.sv
// Shared constants and state encoding for the alpha operand feeder.
package alpha_feed_pkg;

    localparam int unsigned ORDER_DEFAULT  = 12;
    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned ADDR_W_DEFAULT = 4;

    localparam logic [31:0] FP_ONE = 32'h3F80_0000;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/operand_bank.sv
// Register file of DEPTH words: one write port, two combinational read ports.
// Word 0 can be replaced by a constant with no storage behind it.
module operand_bank #(
    parameter int unsigned       DEPTH      = 13,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 4,
    parameter bit                CONST0_EN  = 1'b0,
    parameter logic [DATA_W-1:0] CONST0_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a_c,
    output logic [DATA_W-1:0] rdata_b_c
);

    localparam int unsigned SLOTS = 1 << ADDR_W;

    // Slots beyond DEPTH read as zero, so any address is safe to read.
    logic [DATA_W-1:0] words [SLOTS];

    for (genvar k = 0; k < SLOTS; k++) begin : g_word
        if (k >= DEPTH) begin : g_none
            assign words[k] = '0;
        end else if (CONST0_EN && (k == 0)) begin : g_const
            assign words[k] = CONST0_VAL;
        end else begin : g_reg
            logic [DATA_W-1:0] q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (en && wr && (waddr == ADDR_W'(k))) begin
                    q <= wdata;
                end
            end
            assign words[k] = q;
        end
    end

    assign rdata_a_c = words[raddr_a];
    assign rdata_b_c = words[raddr_b];

endmodule

// File: rtl/alpha_operand_feeder.sv
// Streams model/ACF operand pairs (two products per beat) for the alpha accumulator.
// Optional: define FEED_UNITY_MODEL0_EN to make model[0] a read-only 1.0.
module alpha_operand_feeder
    import alpha_feed_pkg::*;
#(
    parameter int unsigned ORDER  = ORDER_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              iClock,
    input  logic              iResetN,
    input  logic              iEnable,
    input  logic              iACFWrite,
    input  logic [ADDR_W-1:0] iACFAddr,
    input  logic [DATA_W-1:0] iACFData,
    input  logic              iModelWrite,
    input  logic [ADDR_W-1:0] iModelAddr,
    input  logic [DATA_W-1:0] iModelData,
    input  logic              iStart,
    input  logic [3:0]        iM,
    input  logic              iCalcDone,
    output logic [DATA_W-1:0] oACF1,
    output logic [DATA_W-1:0] oACF2,
    output logic [DATA_W-1:0] oModel1,
    output logic [DATA_W-1:0] oModel2,
    output logic              oValid,
    output logic [3:0]        oM,
    output logic              oBusy,
    output logic              oDone,
    output logic              oError
);

    localparam int unsigned IW = ADDR_W + 1;

`ifdef FEED_UNITY_MODEL0_EN
    localparam bit UNITY0 = 1'b1;
`else
    localparam bit UNITY0 = 1'b0;
`endif

    state_t            state, state_nx;
    logic [ADDR_W-1:0] beat, beat_nx;
    logic [3:0]        m_nx;
    logic              done_nx, error_nx, load_c;
    logic [ADDR_W-1:0] rd_beat_c;
    logic [3:0]        rd_m_c;

    logic [IW-1:0]     two_j_c, m_w_c;
    logic              pair_c, last_c, start_ok_c;
    logic [DATA_W-1:0] acf_a_c, acf_b_c, model_a_c, model_b_c;

    // Beat j pairs sum terms 2j and 2j+1; the second exists only while 2j+1 < m.
    assign two_j_c    = IW'(rd_beat_c) << 1;
    assign m_w_c      = IW'(rd_m_c);
    assign pair_c     = (two_j_c + IW'(2)) <= m_w_c;
    assign last_c     = ((IW'(beat) << 1) + IW'(2)) >= IW'(oM);
    assign start_ok_c = (iM != 4'd0) && (32'(iM) <= ORDER);

    operand_bank #(
        .DEPTH(ORDER + 1), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .CONST0_EN(1'b0), .CONST0_VAL('0)
    ) u_acf_bank (
        .clk(iClock), .rst_n(iResetN), .en(iEnable),
        .wr(iACFWrite), .waddr(iACFAddr), .wdata(iACFData),
        .raddr_a(ADDR_W'(m_w_c - two_j_c)),
        .raddr_b(ADDR_W'(m_w_c - two_j_c - IW'(1))),
        .rdata_a_c(acf_a_c), .rdata_b_c(acf_b_c)
    );

    operand_bank #(
        .DEPTH(ORDER + 1), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .CONST0_EN(UNITY0), .CONST0_VAL(DATA_W'(FP_ONE))
    ) u_model_bank (
        .clk(iClock), .rst_n(iResetN), .en(iEnable),
        .wr(iModelWrite), .waddr(iModelAddr), .wdata(iModelData),
        .raddr_a(ADDR_W'(two_j_c)),
        .raddr_b(ADDR_W'(two_j_c + IW'(1))),
        .rdata_a_c(model_a_c), .rdata_b_c(model_b_c)
    );

    // Next state; rd_* select which beat is read for the next registered output.
    always_comb begin
        state_nx  = state;
        beat_nx   = beat;
        m_nx      = oM;
        done_nx   = 1'b0;
        error_nx  = 1'b0;
        load_c    = 1'b0;
        rd_beat_c = beat + ADDR_W'(1);
        rd_m_c    = oM;
        unique case (state)
            S_IDLE: begin
                if (iStart) begin
                    if (start_ok_c) begin
                        state_nx  = S_ISSUE;
                        beat_nx   = '0;
                        m_nx      = iM;
                        rd_beat_c = '0;
                        rd_m_c    = iM;
                        load_c    = 1'b1;
                    end else begin
                        error_nx = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (last_c) begin
                    state_nx = S_WAIT_DONE;
                end else begin
                    beat_nx = beat + ADDR_W'(1);
                    load_c  = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (iCalcDone) begin
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            state   <= S_IDLE;
            beat    <= '0;
            oM      <= '0;
            oValid  <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oError  <= 1'b0;
            oModel1 <= '0;
            oACF2   <= '0;
            oModel2 <= '0;
            oACF1   <= '0;
        end else if (iEnable) begin
            state   <= state_nx;
            beat    <= beat_nx;
            oM      <= m_nx;
            oValid  <= load_c;
            oBusy   <= (state_nx != S_IDLE);
            oDone   <= done_nx;
            oError  <= error_nx;
            oModel1 <= load_c ? model_a_c : '0;
            oACF2   <= load_c ? acf_a_c : '0;
            oModel2 <= (load_c && pair_c) ? model_b_c : '0;
            oACF1   <= (load_c && pair_c) ? acf_b_c : '0;
        end
    end

endmodule

// File: tb/tb_alpha_operand_feeder.sv
// Scoreboard bench for alpha_operand_feeder: expected beats come from pairing the
// terms of sum model[i]*ACF[m-i]; a negedge monitor pops and compares consumed beats.
module tb_alpha_operand_feeder;
    import alpha_feed_pkg::*;

    localparam int ORD = 12;

    logic        iClock, iResetN, iEnable;
    logic        iACFWrite, iModelWrite, iStart, iCalcDone;
    logic [3:0]  iACFAddr, iModelAddr, iM;
    logic [31:0] iACFData, iModelData;
    logic [31:0] oACF1, oACF2, oModel1, oModel2;
    logic        oValid, oBusy, oDone, oError;
    logic [3:0]  oM;

    alpha_operand_feeder dut (
        .iClock(iClock), .iResetN(iResetN), .iEnable(iEnable),
        .iACFWrite(iACFWrite), .iACFAddr(iACFAddr), .iACFData(iACFData),
        .iModelWrite(iModelWrite), .iModelAddr(iModelAddr), .iModelData(iModelData),
        .iStart(iStart), .iM(iM), .iCalcDone(iCalcDone),
        .oACF1(oACF1), .oACF2(oACF2), .oModel1(oModel1), .oModel2(oModel2),
        .oValid(oValid), .oM(oM), .oBusy(oBusy), .oDone(oDone), .oError(oError)
    );

    initial begin
        iClock = 1'b0;
        forever #5 iClock = ~iClock;
    end

    typedef struct packed {
        logic [31:0] m1;
        logic [31:0] a2;
        logic [31:0] m2;
        logic [31:0] a1;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       mon_e;
    logic [31:0] acf_ref [ORD+1];
    logic [31:0] mdl_ref [ORD+1];
    logic [3:0]  exp_m;
    int          checks, errors, done_seen, err_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mdl_val(input int i);
`ifdef FEED_UNITY_MODEL0_EN
        if (i == 0) return FP_ONE;
`endif
        return mdl_ref[i];
    endfunction

    // Beat j carries sum terms 2j and 2j+1 of alpha = sum_{i<m} model[i]*ACF[m-i].
    function automatic beat_t beat_of(input int m, input int j);
        beat_t b;
        int    i;
        i    = 2 * j;
        b.m1 = mdl_val(i);
        b.a2 = acf_ref[m - i];
        if (i + 1 < m) begin
            b.m2 = mdl_val(i + 1);
            b.a1 = acf_ref[m - i - 1];
        end else begin
            b.m2 = 32'h0;
            b.a1 = 32'h0;
        end
        return b;
    endfunction

    task automatic ref_write(input bit wa, input int aa, input logic [31:0] ad,
                             input bit wm, input int ma, input logic [31:0] md);
        if (wa && aa <= ORD) acf_ref[aa] = ad;
`ifdef FEED_UNITY_MODEL0_EN
        if (wm && ma <= ORD && ma != 0) mdl_ref[ma] = md;
`else
        if (wm && ma <= ORD) mdl_ref[ma] = md;
`endif
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic write_pair(input bit wa, input int aa, input logic [31:0] ad,
                              input bit wm, input int ma, input logic [31:0] md);
        iACFWrite = wa;  iACFAddr = 4'(aa);   iACFData = ad;
        iModelWrite = wm; iModelAddr = 4'(ma); iModelData = md;
        step();
        iACFWrite = 1'b0; iModelWrite = 1'b0;
        ref_write(wa, aa, ad, wm, ma, md);
    endtask

    // Consumed beat = oValid at an edge with iEnable high.
    always @(negedge iClock) begin
        if (iResetN && iEnable) begin
            if (oValid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got model1=%h acf2=%h, expected no beat", oModel1, oACF2);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_model1", oModel1, mon_e.m1);
                    chk("beat_acf2", oACF2, mon_e.a2);
                    chk("beat_model2", oModel2, mon_e.m2);
                    chk("beat_acf1", oACF1, mon_e.a1);
                    chk("beat_m", 32'(oM), 32'(exp_m));
                end
            end
            if (oDone) done_seen++;
            if (oError) err_seen++;
        end
    end

    // stall_mode: 0 none, 1 random, 2 low for three cycles while beat 1 is shown.
    task automatic run_op(input int m, input int stall_mode, input bit pre_done,
                          input bit poke, input bit cw);
        int    n, cyc, d0, e0, wa, ma, dly;
        bit    ok;
        beat_t held;
        ok = (m >= 1) && (m <= ORD);
        n  = (m + 1) / 2;
        d0 = done_seen;
        e0 = err_seen;
        iStart = 1'b1; iM = 4'(m); iEnable = 1'b1;
        if (ok) exp_m = 4'(m);
        if (cw) begin
            wa = int'($urandom_range(0, 15));
            ma = int'($urandom_range(0, 15));
            iACFWrite = 1'b1;  iACFAddr = 4'(wa);   iACFData = $urandom;
            iModelWrite = 1'b1; iModelAddr = 4'(ma); iModelData = $urandom;
        end
        // Beat 0 sees storage before a same-edge write, later beats after it.
        if (ok) exp_q.push_back(beat_of(m, 0));
        if (cw) ref_write(1'b1, wa, iACFData, 1'b1, ma, iModelData);
        if (ok) for (int j = 1; j < n; j++) exp_q.push_back(beat_of(m, j));
        step();
        iStart = 1'b0; iACFWrite = 1'b0; iModelWrite = 1'b0;
        if (!ok) begin
            chk("err_pulse", 32'(oError), 32'd1);
            chk("err_busy", 32'(oBusy), 32'd0);
            chk("err_no_valid", 32'(oValid), 32'd0);
            step();
            chk("err_single", 32'(oError), 32'd0);
            chk("err_count", 32'(err_seen - e0), 32'd1);
            chk("err_busy_after", 32'(oBusy), 32'd0);
            return;
        end
        chk("start_latency", 32'(oValid), 32'd1);
        chk("start_busy", 32'(oBusy), 32'd1);
        chk("start_m", 32'(oM), 32'(m));
        cyc = 0;
        while (oValid && cyc < 100) begin
            case (stall_mode)
                1:       iEnable = ($urandom_range(0, 3) != 0);
                2:       iEnable = !(cyc >= 1 && cyc <= 3);
                default: iEnable = 1'b1;
            endcase
            if (stall_mode == 2 && cyc == 1) held = {oModel1, oACF2, oModel2, oACF1};
            if (stall_mode == 2 && cyc == 3) begin
                chk("stall_hold_model1", oModel1, held.m1);
                chk("stall_hold_acf2", oACF2, held.a2);
                chk("stall_hold_model2", oModel2, held.m2);
                chk("stall_hold_acf1", oACF1, held.a1);
            end
            if (poke) begin
                iStart = 1'($urandom_range(0, 1));
                iM     = 4'($urandom_range(0, 15));
            end
            if (pre_done) iCalcDone = 1'b1;
            step();
            cyc++;
        end
        iStart = 1'b0; iEnable = 1'b1;
        chk("issue_bounded", 32'(cyc < 100), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("wait_busy", 32'(oBusy), 32'd1);
        chk("wait_operands_zero", oModel1 | oACF2 | oModel2 | oACF1, 32'd0);
        chk("wait_m_held", 32'(oM), 32'(m));
        if (!pre_done) begin
            dly = int'($urandom_range(0, 3));
            repeat (dly) begin
                step();
                chk("no_early_done", 32'(oDone), 32'd0);
            end
            iCalcDone = 1'b1;
        end
        step();
        chk("done_pulse", 32'(oDone), 32'd1);
        chk("done_idle", 32'(oBusy), 32'd0);
        iCalcDone = 1'b0;
        step();
        chk("done_single", 32'(oDone), 32'd0);
        chk("done_count", 32'(done_seen - d0), 32'd1);
    endtask

    initial begin
        int d0, r;
        checks = 0; errors = 0; done_seen = 0; err_seen = 0; exp_m = 4'd0;
        iResetN = 1'b0; iEnable = 1'b1; iStart = 1'b0; iM = 4'd0; iCalcDone = 1'b0;
        iACFWrite = 1'b0; iACFAddr = 4'd0; iACFData = 32'h0;
        iModelWrite = 1'b0; iModelAddr = 4'd0; iModelData = 32'h0;
        for (int k = 0; k <= ORD; k++) begin
            acf_ref[k] = 32'h0;
            mdl_ref[k] = 32'h0;
        end
        repeat (3) @(posedge iClock);
        #1;
        chk("reset_valid", 32'(oValid), 32'd0);
        chk("reset_busy", 32'(oBusy), 32'd0);
        chk("reset_done", 32'(oDone), 32'd0);
        chk("reset_error", 32'(oError), 32'd0);
        chk("reset_m", 32'(oM), 32'd0);
        chk("reset_operands", oModel1 | oACF2 | oModel2 | oACF1, 32'd0);
        iResetN = 1'b1;
        step();

        for (int k = 0; k <= ORD; k++)
            write_pair(1'b1, k, 32'h0000_0A00 + 32'(k), 1'b1, k, 32'h0000_0B00 + 32'(k));
        write_pair(1'b1, 14, 32'hDEAD_0000, 1'b1, 15, 32'hDEAD_0001);

        run_op(1, 0, 1'b0, 1'b0, 1'b0);
        run_op(4, 0, 1'b0, 1'b0, 1'b0);
        run_op(5, 0, 1'b0, 1'b1, 1'b0);
        run_op(5, 2, 1'b0, 1'b0, 1'b0);
        run_op(0, 0, 1'b0, 1'b0, 1'b0);
        run_op(13, 0, 1'b0, 1'b0, 1'b0);
        run_op(12, 0, 1'b1, 1'b0, 1'b0);
        write_pair(1'b0, 0, 32'h0, 1'b1, 0, 32'h4000_0000);
        run_op(2, 0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of an m=8 stream.
        d0 = done_seen;
        iStart = 1'b1; iM = 4'd8; exp_m = 4'd8;
        for (int j = 0; j < 4; j++) exp_q.push_back(beat_of(8, j));
        step();
        iStart = 1'b0;
        step();
        #1 iResetN = 1'b0;
        #1;
        chk("async_valid", 32'(oValid), 32'd0);
        chk("async_busy", 32'(oBusy), 32'd0);
        chk("async_m", 32'(oM), 32'd0);
        chk("async_operands", oModel1 | oACF2 | oModel2 | oACF1, 32'd0);
        exp_q.delete();
        for (int k = 0; k <= ORD; k++) begin
            acf_ref[k] = 32'h0;
            mdl_ref[k] = 32'h0;
        end
        step();
        step();
        #2 iResetN = 1'b1;
        step();
        step();
        chk("reset_no_done", 32'(done_seen - d0), 32'd0);
        run_op(3, 0, 1'b0, 1'b0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 2))
                write_pair(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
                           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom);
            r = int'($urandom_range(0, 15));
            run_op(r, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alpha_operand_feeder.md
Name: alpha_operand_feeder

Overview:
- Upstream stage of the alpha accumulator in the Levinson-Durbin LPC path.
- Holds the autocorrelation vector ACF[0..ORDER] and the current model vector model[0..ORDER].
- On a start request for iteration m, streams operand pairs, two products per beat, so the accumulator forms alpha = sum_{i=0}^{m-1} model[i]*ACF[m-i].
- Treats data as opaque 32-bit words; contains no floating-point arithmetic.

Parameters:
- ORDER, 12, maximum LPC order; storage depth is ORDER+1.
- DATA_W, 32, word width (IEEE single).
- ADDR_W, 4, storage address width; must satisfy 2^ADDR_W > ORDER.

Ports:
- iClock  in  1  clock, rising-edge.
- iResetN  in  1  asynchronous active-low reset.
- iEnable  in  1  global stall; when low, all state, outputs and storage hold, including writes.
- iACFWrite  in  1  ACF write strobe.
- iACFAddr  in  ADDR_W  ACF write address.
- iACFData  in  DATA_W  ACF write data.
- iModelWrite  in  1  model write strobe.
- iModelAddr  in  ADDR_W  model write address.
- iModelData  in  DATA_W  model write data.
- iStart  in  1  start request, sampled in IDLE only.
- iM  in  4  iteration index m, sampled with iStart.
- iCalcDone  in  1  downstream accumulator done, level.
- oACF1, oACF2, oModel1, oModel2  out  DATA_W  operand beat.
- oValid  out  1  beat valid.
- oM  out  4  latched m, held stable for the downstream stage.
- oBusy  out  1  high outside IDLE.
- oDone  out  1  one-cycle completion pulse.
- oError  out  1  one-cycle pulse on rejected start.

Behaviour:
- Reset (async assert, sync release): all storage words, operand outputs and oM = 0; oValid, oBusy, oDone, oError = 0; state = IDLE; beat counter j = 0.
- Storage writes:
  - Take effect at the clock edge when iEnable=1.
  - Address > ORDER: ignored.
  - ACF and model may be written in the same cycle.
  - A write in the same cycle as a read to the same address returns the old value; the new value is visible from the next beat.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - iStart=1 with 1<=iM<=ORDER: latch m into oM, j=0, go to ISSUE. First oValid appears the next cycle, so latency from iStart is 1 cycle.
  - iStart=1 with iM=0 or iM>ORDER: oError pulses one cycle, state stays IDLE.
- ISSUE: one registered beat per enabled cycle, beats contiguous, N = ceil(m/2) beats total. Beat j drives:
  - oModel1 = model[2j], oACF2 = ACF[m-2j]
  - oModel2 = model[2j+1], oACF1 = ACF[m-2j-1] when 2j+1 <= m-1; otherwise both 0
  - After beat N-1: go to WAIT_DONE, and oValid and all operand outputs = 0 on the next cycle.
- WAIT_DONE:
  - oValid=0.
  - When iCalcDone=1: oDone pulses one cycle, then IDLE.
  - If iCalcDone is already high on entry, oDone fires in the first WAIT_DONE cycle.
- iStart while oBusy=1: ignored, no error.
- iEnable=0 mid-ISSUE: the current beat's outputs and oValid hold. The downstream accumulator shares iEnable, so it sees no duplicate beat.
- Reset mid-operation: immediate return to reset values; no oDone is produced.

Optional Feature:
- Macro FEED_UNITY_MODEL0_EN.
- Defined: model[0] reads as the constant 0x3F800000 (1.0); model writes to address 0 are ignored; that word needs no storage.
- Undefined: model[0] is an ordinary writable word.

Decomposition:
- Package alpha_feed_pkg holds:
  - state encoding localparams S_IDLE=0, S_ISSUE=1, S_WAIT_DONE=2
  - FP_ONE = 32'h3F800000
  - the default ORDER value
- Sub-module operand_bank: (ORDER+1)-word register file with one write port and two combinational read ports, async clear. Instantiated twice, once for ACF and once for model.

Test Plan:
- Preload ACF[k]=32'h00000A00+k and model[k]=32'h00000B00+k (no unity macro); iStart with iM=1 -> exactly 1 beat (B00, A01, 0, 0) as (oModel1, oACF2, oModel2, oACF1) one cycle after iStart; oDone one cycle after iCalcDone.
- Same preload, iM=4 -> beats (B00,A04,B01,A03) then (B02,A02,B03,A01); oValid high exactly 2 cycles.
- Same preload, iM=5 -> 3 beats, last (B04,A01,0,0); iStart pulsed during ISSUE is ignored; oM=5 throughout.
- iM=5 with iEnable low 3 cycles during beat 1 -> beat 1 values held; total enabled oValid cycles = 3; sequence unchanged.
- iM=0 and iM=13 -> single oError pulse, oBusy stays 0, no oValid; drop iResetN mid-ISSUE of iM=8 -> all outputs 0 asynchronously, storage cleared, no oDone.
- With FEED_UNITY_MODEL0_EN defined, write model[0]=0x40000000, iM=2 -> beat (3F800000, ACF[2], model[1], ACF[1]).
